v5_shaper_ctrl: RTL and testbench
=================================

// Module: v5_shaper_ctrl
// PURPOSE
// Sequencer and event extractor for the v5 trapezoidal shaping filter.
// - Holds the filter in reset until enabled, then waits out the filter pipeline fill.
// - Detects threshold crossings on the filter output and captures the pulse peak and timestamp.
// - Presents each event on a valid/ready port and enforces a programmable hold-off.
// Sits between the v5 filter output and the event readout FIFO.
// PARAMETERS
// DW        20  width of filter output / threshold, signed two's complement
// K         16  filter k length (delay taps)
// L         8   filter l length (delay taps)
// PIPE      6   filter register stages after the delay line
// MAX_WIDTH 255 max PEAK-state cycles before forced report with pileup
// TW        32  timestamp width
// HW        16  hold-off counter width
// PORTS
// clk          in  1   system clock, all logic on rising edge
// reset        in  1   asynchronous, active-low reset
// enable       in  1   run request; level sensitive
// cfg_load     in  1   pulse: latch cfg_threshold/cfg_holdoff (honoured in IDLE only)
// cfg_threshold in DW  signed trigger threshold
// cfg_holdoff  in  HW  hold-off cycles after each accepted event
// filt_rst_n   out 1   drives filter reset input, active-low
// filt_data    in  DW  signed filter output
// evt_valid    out 1   event available
// evt_ready    in  1   downstream accepts event
// evt_peak     out DW  signed maximum filt_data during pulse
// evt_time     out TW  timestamp of threshold crossing
// evt_pileup   out 1   pulse overran MAX_WIDTH or followed a hold-off retrigger
// miss_cnt     out 16  saturating count of crossings ignored in HOLDOFF
// busy         out 1   1 in every state except IDLE
// BEHAVIOUR
// Reset (reset=0):
// - State IDLE; filt_rst_n=0.
// - evt_valid, evt_peak, evt_time, evt_pileup, miss_cnt, busy, tstamp all 0.
// - Threshold and hold-off config registers are 0.
// Reset asserted mid-operation aborts immediately; a pending event is lost.
// tstamp: free-running TW-bit counter from reset release; wraps modulo 2^TW, no flag.
// States and transitions (one transition per clock):
// - IDLE: filt_rst_n=0.
//   - cfg_load=1 latches the config.
//   - enable=1 -> INIT. If cfg_load and enable are both 1, the config is latched first and then used.
// - INIT: filt_rst_n=0 for exactly 2 cycles -> SETTLE.
// - SETTLE: filt_rst_n=1. Counts K+L+PIPE cycles -> ARMED; filt_data is ignored throughout.
// - ARMED: filt_data > thr (strictly signed) -> PEAK.
//   - On the transition: peak<=filt_data, evt_time<=tstamp of that cycle, width<=1.
// - PEAK: update peak if filt_data > peak; width++.
//   - filt_data <= thr -> REPORT, pileup=pend.
//   - width==MAX_WIDTH -> REPORT, pileup=1.
//   - Both true in one cycle: pileup=1.
// - REPORT: evt_valid=1; evt_peak, evt_time and evt_pileup held stable.
//   - valid && ready -> clear pend, evt_valid=0 next cycle.
//   - Then HOLDOFF, or ARMED directly if holdoff==0.
//   - ready may be held high; the minimum valid pulse is 1 cycle.
// - HOLDOFF: counts holdoff cycles -> ARMED.
//   - Each rising crossing (filt_data>thr while the previous sample was <=thr) sets pend=1 and increments miss_cnt, saturating at 0xFFFF.
// Enable rules:
// - enable=0 in INIT, SETTLE, ARMED or HOLDOFF -> IDLE next cycle.
// - enable=0 in PEAK or REPORT: the event completes and is handshaken, then -> IDLE.
// - Every IDLE->INIT re-runs the filter reset and settle.
// cfg_load outside IDLE is ignored; the config cannot change mid-run.
// Filter reset handling: the filter is reset to all-zero; the controller never feeds the filter.
// Latency: crossing sample at cycle t -> earliest evt_valid at t+2, when the pulse lasts exactly 1 sample above threshold.
// TESTING
// - Startup: reset release, enable=1 -> filt_rst_n low 2 cycles, then high; ARMED exactly K+L+PIPE=30 cycles later; crossings during SETTLE give no event.
// - Single pulse, thr=100: filt_data 50,150,400,300,90 -> evt_peak=400, evt_time=tstamp at the 150 sample, evt_pileup=0.
// - Back-pressure: evt_ready=0 for 10 cycles -> evt_valid held and fields stable; ready=1 -> valid drops next cycle, HOLDOFF starts.
// - Hold-off retrigger: holdoff=20, new crossing 5 cycles into HOLDOFF -> no event, miss_cnt=1, next event evt_pileup=1.
// - Long pulse: filt_data=500 held for 300 cycles, thr=100 -> report after 255 PEAK cycles with evt_pileup=1.
// - Negative/edge values: thr=-10, filt_data=-10 -> no trigger; -9 -> trigger. Reset during REPORT -> all outputs 0. Timestamp wrap at 2^32-1 -> 0 is reported unchanged.

Source files
------------

// File: rtl/v5_shaper_ctrl.sv
// Sequencer and event extractor for the v5 trapezoidal shaping filter: filter reset and settle,
// threshold-crossing peak/timestamp capture, and a valid/ready event port with hold-off.
module v5_shaper_ctrl #(
    parameter int DW        = 20,
    parameter int K         = 16,
    parameter int L         = 8,
    parameter int PIPE      = 6,
    parameter int MAX_WIDTH = 255,
    parameter int TW        = 32,
    parameter int HW        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 cfg_load,
    input  logic signed [DW-1:0] cfg_threshold,
    input  logic [HW-1:0]        cfg_holdoff,
    output logic                 filt_rst_n,
    input  logic signed [DW-1:0] filt_data,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic signed [DW-1:0] evt_peak,
    output logic [TW-1:0]        evt_time,
    output logic                 evt_pileup,
    output logic [15:0]          miss_cnt,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_ARMED   = 3'd3;
    localparam logic [2:0] S_PEAK    = 3'd4;
    localparam logic [2:0] S_REPORT  = 3'd5;
    localparam logic [2:0] S_HOLDOFF = 3'd6;

    localparam int SETTLE_CYCLES = K + L + PIPE;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = (HW > SW) ? HW : SW;
    localparam int WW = $clog2(MAX_WIDTH + 1);

    localparam logic [CW-1:0] INIT_LAST   = CW'(1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [WW-1:0] WIDTH_MAX   = WW'(MAX_WIDTH);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [CW-1:0]        cnt;
    logic                 cnt_done;
    logic signed [DW-1:0] thr;
    logic [HW-1:0]        holdoff;
    logic [WW-1:0]        width;
    logic                 pend;
    logic                 prev_above;
    logic                 above;
    logic                 rise;
    logic                 handshake;
    logic [TW-1:0]        tstamp;

    assign above     = filt_data > thr;
    assign rise      = above && !prev_above;
    assign handshake = (state == S_REPORT) && evt_ready;

    assign evt_valid  = (state == S_REPORT);
    assign busy       = (state != S_IDLE);
    assign filt_rst_n = (state != S_IDLE) && (state != S_INIT);

    // One up-counter serves INIT, SETTLE and HOLDOFF; it restarts on every state change.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        cnt_done = 1'b0;
        case (state)
            S_INIT:    cnt_done = (cnt == INIT_LAST);
            S_SETTLE:  cnt_done = (cnt == SETTLE_LAST);
            S_HOLDOFF: cnt_done = (cnt == (CW'(holdoff) - CW'(1)));
            default:   cnt_done = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (enable) state_nxt = S_INIT;
            end
            S_INIT, S_SETTLE: begin
                if (!enable)        state_nxt = S_IDLE;
                else if (cnt_done)  state_nxt = (state == S_INIT) ? S_SETTLE : S_ARMED;
            end
            S_ARMED: begin
                if (!enable)        state_nxt = S_IDLE;
                else if (above)     state_nxt = S_PEAK;
            end
            S_PEAK: begin
                if (!above || (width == WIDTH_MAX)) state_nxt = S_REPORT;
            end
            S_REPORT: begin
                if (evt_ready) begin
                    if (!enable)            state_nxt = S_IDLE;
                    else if (holdoff == '0) state_nxt = S_ARMED;
                    else                    state_nxt = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (!enable)        state_nxt = S_IDLE;
                else if (cnt_done)  state_nxt = S_ARMED;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            thr        <= '0;
            holdoff    <= '0;
            width      <= '0;
            pend       <= 1'b0;
            prev_above <= 1'b0;
            tstamp     <= '0;
            evt_peak   <= '0;
            evt_time   <= '0;
            evt_pileup <= 1'b0;
            miss_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop sees the values from before this edge.
            state      <= state_nxt;
            tstamp     <= tstamp + TW'(1);
            cnt        <= (state_nxt != state) ? '0 : cnt + CW'(1);
            prev_above <= above;

            if ((state == S_IDLE) && cfg_load) begin
                thr     <= cfg_threshold;
                holdoff <= cfg_holdoff;
            end

            if ((state == S_ARMED) && (state_nxt == S_PEAK)) begin
                evt_peak <= filt_data;
                evt_time <= tstamp;
                width    <= WW'(1);
            end

            if (state == S_PEAK) begin
                if (filt_data > evt_peak) evt_peak <= filt_data;
                width <= width + WW'(1);
                if (state_nxt == S_REPORT) evt_pileup <= pend || (width == WIDTH_MAX);
            end

            // A crossing swallowed by the hold-off taints the next reported event.
            if (handshake) begin
                pend <= 1'b0;
            end else if ((state == S_HOLDOFF) && rise) begin
                pend <= 1'b1;
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_v5_shaper_ctrl.sv
// Self-checking bench for v5_shaper_ctrl: directed scenarios plus randomized pulses, with events
// predicted from the sample stream (max, crossing time, width limit, hold-off retrigger flag).
module tb_v5_shaper_ctrl;

    localparam int DW        = 20;
    localparam int MAX_WIDTH = 255;
    localparam int SETTLE    = 30;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 enable = 1'b0;
    logic                 cfg_load = 1'b0;
    logic                 evt_ready = 1'b0;
    logic signed [DW-1:0] cfg_threshold = '0;
    logic signed [DW-1:0] filt_data = '0;
    logic [15:0]          cfg_holdoff = '0;

    logic                 filt_rst_n, evt_valid, evt_pileup, busy;
    logic signed [DW-1:0] evt_peak;
    logic [31:0]          evt_time;
    logic [15:0]          miss_cnt;

    logic                 w_filt_rst_n, w_evt_valid, w_evt_pileup, w_busy;
    logic signed [DW-1:0] w_evt_peak;
    logic [7:0]           w_evt_time;
    logic [15:0]          w_miss_cnt;

    int                   checks = 0;
    int                   errors = 0;
    logic [31:0]          ts_model;
    logic signed [DW-1:0] model_thr;
    int                   model_holdoff;
    bit                   model_pend;
    int                   exp_miss;
    logic signed [DW-1:0] seq[$];

    v5_shaper_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
        .cfg_threshold(cfg_threshold), .cfg_holdoff(cfg_holdoff),
        .filt_rst_n(filt_rst_n), .filt_data(filt_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_peak(evt_peak),
        .evt_time(evt_time), .evt_pileup(evt_pileup), .miss_cnt(miss_cnt), .busy(busy)
    );

    // Narrow-timestamp copy on the same inputs: its evt_time must be the wide one modulo 256.
    v5_shaper_ctrl #(.TW(8)) u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
        .cfg_threshold(cfg_threshold), .cfg_holdoff(cfg_holdoff),
        .filt_rst_n(w_filt_rst_n), .filt_data(filt_data),
        .evt_valid(w_evt_valid), .evt_ready(evt_ready), .evt_peak(w_evt_peak),
        .evt_time(w_evt_time), .evt_pileup(w_evt_pileup), .miss_cnt(w_miss_cnt), .busy(w_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) ts_model <= '0;
        else        ts_model <= ts_model + 32'd1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic signed [DW-1:0] d);
        filt_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(DW'(model_thr - 1));
    endtask

    task automatic add(input int v, input int n);
        for (int i = 0; i < n; i++) seq.push_back(DW'(v));
    endtask

    // Enable from IDLE: two cycles of filter reset, then SETTLE cycles with data ignored.
    task automatic startup(input logic signed [DW-1:0] settle_data);
        enable = 1'b1;
        step(settle_data);
        cfg_load = 1'b0;
        check("init_busy", busy, 1);
        check("init_rst_a", filt_rst_n, 0);
        step(settle_data);
        check("init_rst_b", filt_rst_n, 0);
        step(settle_data);
        check("settle_rst", filt_rst_n, 1);
        for (int i = 0; i < SETTLE; i++) step(settle_data);
        check("settle_no_evt", evt_valid, 0);
    endtask

    // Plays seq into an armed controller, predicts the event, then handshakes it.
    task automatic play_event(input int ready_delay, input int drop_en_at);
        int                   i0;
        int                   last;
        logic signed [DW-1:0] pk;
        logic [31:0]          t_exp;
        bit                   pil;
        i0 = -1;
        t_exp = '0;
        for (int i = 0; i < seq.size(); i++)
            if (i0 < 0 && seq[i] > model_thr) i0 = i;
        pk   = seq[i0];
        last = i0;
        pil  = model_pend;
        for (int j = 1; i0 + j < seq.size(); j++) begin
            last = i0 + j;
            if (seq[last] > pk) pk = seq[last];
            if (j == MAX_WIDTH) begin
                pil = 1'b1;
                break;
            end
            if (seq[last] <= model_thr) break;
        end
        for (int i = 0; i <= last; i++) begin
            if (i == drop_en_at) enable = 1'b0;
            if (i == i0) t_exp = ts_model;
            if (i == last) check("valid_early", evt_valid, 0);
            step(seq[i]);
        end
        check("valid_rise", evt_valid, 1);
        check("peak", evt_peak, pk);
        check("time", evt_time, t_exp);
        check("pileup", evt_pileup, pil);
        check("time_wrap", w_evt_time, t_exp[7:0]);
        for (int i = last + 1; i < seq.size(); i++) step(seq[i]);
        for (int i = 0; i < ready_delay; i++) begin
            quiet(1);
            check("valid_hold", evt_valid, 1);
        end
        if (ready_delay > 0 || last + 1 < seq.size()) begin
            check("valid_hold_end", evt_valid, 1);
            check("peak_hold", evt_peak, pk);
            check("time_hold", evt_time, t_exp);
            check("pileup_hold", evt_pileup, pil);
        end
        evt_ready = 1'b1;
        quiet(1);
        evt_ready = 1'b0;
        check("valid_drop", evt_valid, 0);
        check("busy_after", busy, enable);
        check("miss_cnt", miss_cnt, exp_miss);
        model_pend = 1'b0;
        seq.delete();
    endtask

    initial begin
        int thr_i;
        int n;
        model_thr = '0;
        model_holdoff = 0;
        model_pend = 1'b0;
        exp_miss = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", evt_valid, 0);
        check("rst_peak", evt_peak, 0);
        check("rst_time", evt_time, 0);
        check("rst_pileup", evt_pileup, 0);
        check("rst_miss", miss_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_filt", filt_rst_n, 0);
        reset = 1'b1;
        step(0);
        step(0);
        check("idle_busy", busy, 0);
        check("idle_filt", filt_rst_n, 0);

        // Config load and enable in the same cycle; settle data far above threshold.
        cfg_threshold = 20'sd100;
        cfg_holdoff = 16'd20;
        cfg_load = 1'b1;
        model_thr = 20'sd100;
        model_holdoff = 20;
        startup(20'sd1000);

        // First pulse in the first ARMED cycle, ends on a sample equal to threshold; back-pressure.
        add(150, 1); add(220, 1); add(130, 1); add(100, 1);
        play_event(10, -1);

        // Retrigger five cycles into a 20-cycle hold-off.
        for (int i = 0; i < 4; i++) step(0);
        for (int i = 0; i < 3; i++) step(200);
        exp_miss = 1;
        model_pend = 1'b1;
        check("retrig_no_evt", evt_valid, 0);
        check("retrig_miss", miss_cnt, exp_miss);
        for (int i = 0; i < 13; i++) step(0);
        add(0, 1); add(250, 1); add(120, 1); add(0, 1);
        play_event(0, -1);
        quiet(model_holdoff);

        add(50, 1); add(150, 1); add(400, 1); add(300, 1); add(90, 1);
        play_event(1, -1);
        quiet(model_holdoff);

        // Long pulse forced out by the width limit.
        add(500, 300);
        play_event(2, -1);
        quiet(model_holdoff);

        enable = 1'b0;
        quiet(1);
        check("dis_busy", busy, 0);
        check("dis_filt", filt_rst_n, 0);

        // Negative threshold, zero hold-off, ready held high.
        cfg_threshold = -20'sd10;
        cfg_holdoff = 16'd0;
        cfg_load = 1'b1;
        model_thr = -20'sd10;
        model_holdoff = 0;
        quiet(1);
        cfg_load = 1'b0;
        startup(-20'sd10);
        evt_ready = 1'b1;
        add(-10, 2); add(-9, 1); add(-20, 1);
        play_event(0, -1);

        // A config load while running must not change the threshold.
        cfg_threshold = 20'sd1000;
        cfg_load = 1'b1;
        quiet(1);
        cfg_load = 1'b0;
        add(-20, 1); add(-5, 1); add(-11, 1);
        play_event(1, -1);

        // Enable dropped mid-pulse: event still completes, then IDLE.
        add(-3, 1); add(-1, 1); add(-2, 1); add(-30, 1);
        play_event(0, 2);

        // Reset while an event is pending.
        startup(-20'sd10);
        step(-20'sd5);
        step(-20'sd20);
        check("rpt_valid", evt_valid, 1);
        #2 reset = 1'b0;
        #1;
        exp_miss = 0;
        check("arst_valid", evt_valid, 0);
        check("arst_peak", evt_peak, 0);
        check("arst_time", evt_time, 0);
        check("arst_pileup", evt_pileup, 0);
        check("arst_miss", miss_cnt, exp_miss);
        check("arst_busy", busy, 0);
        check("arst_filt", filt_rst_n, 0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_thr = '0;
        model_holdoff = 0;
        model_pend = 1'b0;
        step(0);

        // Config registers came back as zero: threshold 0, no hold-off.
        startup(20'sd0);
        add(0, 2); add(1, 1); add(0, 1);
        play_event(0, -1);
        add(3, 1); add(-4, 1);
        play_event(0, -1);

        // Randomized configurations and pulses.
        for (int c = 0; c < 3; c++) begin
            enable = 1'b0;
            quiet(1);
            thr_i = int'($urandom_range(0, 200000)) - 100000;
            model_thr = DW'(thr_i);
            model_holdoff = int'($urandom_range(0, 12));
            cfg_threshold = model_thr;
            cfg_holdoff = 16'(model_holdoff);
            cfg_load = 1'b1;
            quiet(1);
            cfg_load = 1'b0;
            startup(DW'(thr_i + 5000));
            for (int p = 0; p < 6; p++) begin
                n = int'($urandom_range(0, 3));
                for (int i = 0; i < n; i++) add(thr_i - int'($urandom_range(0, 5000)), 1);
                n = int'($urandom_range(1, 12));
                for (int i = 0; i < n; i++) add(thr_i + 1 + int'($urandom_range(0, 30000)), 1);
                add(thr_i - int'($urandom_range(0, 5000)), 1);
                play_event(int'($urandom_range(0, 3)), -1);
                quiet(model_holdoff + int'($urandom_range(0, 2)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
